// File: rtl/arb_mux_rr.sv
// arb_mux_rr: N-to-1 registered multiplexer with fixed-select or round-robin arbitration.
// One output register stage; in_ready is combinational, one-hot or zero.
module arb_mux_rr #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 4,
  parameter int unsigned SELW  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_src,
  input  logic               out_ready
);

  logic             load_en;
  logic             gnt_any;
  logic             xfer;
  logic [SELW-1:0]  gnt_idx;
  logic [SELW-1:0]  last_grant;
  logic [WIDTH-1:0] gnt_data;

  assign load_en = !out_valid || out_ready;
  assign xfer    = load_en && gnt_any;

  // Round-robin: each channel's distance from last_grant+1 in modulo-N order;
  // the valid channel with the smallest distance wins.
  always_comb begin
    int unsigned best_d;
    int unsigned d;
    gnt_any = 1'b0;
    gnt_idx = '0;
    best_d  = N;
    d       = 0;
    if (!mode) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (sel == SELW'(i) && in_valid[i]) begin
          gnt_any = 1'b1;
          gnt_idx = SELW'(i);
        end
      end
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        d = (i + N - 32'(last_grant) - 1) % N;
        if (in_valid[i] && d < best_d) begin
          best_d  = d;
          gnt_any = 1'b1;
          gnt_idx = SELW'(i);
        end
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (gnt_idx == SELW'(i))
        gnt_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    in_ready = '0;
    for (int unsigned i = 0; i < N; i++)
      in_ready[i] = rst_n && load_en && gnt_any && (gnt_idx == SELW'(i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_src    <= '0;
      last_grant <= SELW'(N - 1);
    end else if (load_en) begin
      if (xfer) begin
        out_valid  <= 1'b1;
        out_data   <= gnt_data;
        out_src    <= gnt_idx;
        last_grant <= gnt_idx;
      end else begin
        out_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arb_mux_rr.sv
// Self-checking bench for arb_mux_rr: directed vector table, stall/reset sequences,
// and randomized traffic against a behavioural model.
module tb_arb_mux_rr;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned N     = 4;
  localparam int unsigned SELW  = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [N-1:0]       in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_ready;
  logic               mode;
  logic [SELW-1:0]    sel;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_src;
  logic               out_ready;

  always #5 clk = ~clk;

  arb_mux_rr #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_valid(out_valid),
    .out_data(out_data), .out_src(out_src), .out_ready(out_ready)
  );

  int tests = 0;
  int fails = 0;

  // Model of the output register and arbitration history
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  int               m_src;
  int               m_last;

  typedef struct {
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  valid;
    logic        ordy;
    logic [3:0]  exp_rdy;
    logic        exp_v;
    logic [1:0]  exp_src;
    logic [31:0] exp_data;
  } vec_t;
  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_src   = 0;
    m_last  = N - 1;
  endtask

  function automatic int ref_grant();
    if (mode == 1'b0)
      return (int'(sel) < N && in_valid[sel]) ? int'(sel) : -1;
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_last + k) % N;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  // Check in_ready against the model, take one clock edge, advance the model.
  task automatic tick();
    int  g;
    logic ld;
    #1;
    ld = !m_valid || out_ready;
    g  = ld ? ref_grant() : -1;
    chk("in_ready", 32'(in_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
    @(posedge clk);
    if (g >= 0) begin
      m_valid = 1'b1;
      m_data  = in_data[g*WIDTH +: WIDTH];
      m_src   = g;
      m_last  = g;
    end else if (ld) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic chk_model();
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data", out_data, m_data);
    chk("out_src", 32'(out_src), 32'(m_src));
  endtask

  initial begin
    tbl[0]  = '{1'b0, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'd0};
    tbl[1]  = '{1'b0, 2'd1, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 32'd2};
    tbl[2]  = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 32'd4};
    tbl[3]  = '{1'b0, 2'd3, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 32'd8};
    tbl[4]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'd0};
    tbl[5]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 32'd2};
    tbl[6]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 32'd4};
    tbl[7]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 32'd8};
    tbl[8]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'd0};
    tbl[9]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 32'd2};
    tbl[10] = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3, 32'd8};
    tbl[11] = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 32'd2};
    tbl[12] = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3, 32'd8};
    tbl[13] = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 32'd2};
    tbl[14] = '{1'b0, 2'd2, 4'b1011, 1'b1, 4'b0000, 1'b0, 2'd1, 32'd2};
    tbl[15] = '{1'b0, 2'd2, 4'b1011, 1'b1, 4'b0000, 1'b0, 2'd1, 32'd2};

    model_reset();
    in_valid  = 4'b1111;
    in_data   = {32'd8, 32'd4, 32'd2, 32'd0};
    mode      = 1'b1;
    sel       = '0;
    out_ready = 1'b1;

    #2;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_data", out_data, 32'd0);
    chk("reset out_src", 32'(out_src), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd0);
    in_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      mode      = tbl[i].mode;
      sel       = tbl[i].sel;
      in_valid  = tbl[i].valid;
      out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(tbl[i].exp_rdy));
      tick();
      chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(tbl[i].exp_v));
      chk($sformatf("vec%0d out_src", i), 32'(out_src), 32'(tbl[i].exp_src));
      chk($sformatf("vec%0d out_data", i), out_data, tbl[i].exp_data);
    end

    // Stall: word 4 held while out_ready is low, then next word loads on release
    @(negedge clk);
    mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
    tick();
    chk("stall load", out_data, 32'd4);
    @(negedge clk);
    out_ready = 1'b0; sel = 2'd3;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall in_ready", 32'(in_ready), 32'd0);
      chk("stall out_data", out_data, 32'd4);
      chk("stall out_valid", 32'(out_valid), 32'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    tick();
    chk("release out_data", out_data, 32'd8);
    chk("release out_src", 32'(out_src), 32'd3);

    // Reset asserted mid-cycle while stalled on word 8
    @(negedge clk);
    out_ready = 1'b0;
    tick();
    chk("held 8", out_data, 32'd8);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst out_valid", 32'(out_valid), 32'd0);
    chk("async rst out_data", out_data, 32'd0);
    chk("async rst out_src", 32'(out_src), 32'd0);
    chk("async rst in_ready", 32'(in_ready), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1; mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    tick();
    chk("post-reset rr src", 32'(out_src), 32'd0);
    chk("post-reset rr data", out_data, 32'd0);
    chk_model();

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      mode      = ($urandom_range(0, 3) != 0);
      sel       = SELW'($urandom_range(0, N - 1));
      in_valid  = N'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = $urandom;
      tick();
      chk_model();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
